onehot_encoder_stream: RTL and testbench

Streaming one-hot to binary encoder, the inverse of the 2x4 decoder blocks used to build the gate library. Accepts decoder-style N-bit one-hot words over a valid/ready handshake and returns the binary index with an error flag for zero-hot or multi-hot input. It has one registered output stage plus a one-entry skid buffer, so it sustains one word per cycle under back-pressure. It sits between decoder-based select logic and any consumer that needs a compact index.

---
 rtl/encoder_pkg.sv | 8 +
 rtl/onehot_prio_enc.sv | 17 +
 rtl/onehot_encoder_stream.sv | 90 +++++++++
 tb/tb_onehot_encoder_stream.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/encoder_pkg.sv
// encoder_pkg: shared types and constants for the one-hot encoder stream.
package encoder_pkg;
    localparam int N_DEF = 4;
    localparam int W_DEF = $clog2(N_DEF);
    localparam int ERR_CNT_W = 8;
    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
endpackage

// File: rtl/onehot_prio_enc.sv
// onehot_prio_enc: combinational highest-bit priority encoder flagging non-one-hot codes.
module onehot_prio_enc #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] code,
    output logic [W-1:0] idx,
    output logic         err
);
    always_comb begin
        idx = '0;
        for (int i = 0; i < N; i++)
            if (code[i]) idx = W'(i);
    end
    // zero-hot, or any bit still set after clearing the lowest one
    assign err = ~|code | |(code & (code - 1'b1));
endmodule

// File: rtl/onehot_encoder_stream.sv
// onehot_encoder_stream: one-hot to binary index over valid/ready with a one-entry skid buffer.
// Define ENCODER_ERR_CNT_EN to add the saturating err_cnt output.
module onehot_encoder_stream
    import encoder_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_code,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_idx,
    output logic         out_err
`ifdef ENCODER_ERR_CNT_EN
    ,
    output logic [ERR_CNT_W-1:0] err_cnt
`endif
);
    state_t state;
    logic [W-1:0] enc_idx, skid_idx;
    logic enc_err, skid_err;
    logic acc, pop;

    assign acc = in_valid & in_ready;
    assign pop = out_valid & out_ready;

    onehot_prio_enc #(.N(N), .W(W)) u_enc (
        .code(in_code),
        .idx (enc_idx),
        .err (enc_err)
    );

    // in_ready and out_valid are registered alongside the state they mirror
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_err   <= 1'b0;
            skid_idx  <= '0;
            skid_err  <= 1'b0;
        end else begin
            case (state)
                EMPTY: if (acc) begin
                    state     <= ONE;
                    out_valid <= 1'b1;
                    out_idx   <= enc_idx;
                    out_err   <= enc_err;
                end
                ONE: if (acc && pop) begin
                    out_idx <= enc_idx;
                    out_err <= enc_err;
                end else if (acc) begin
                    state    <= TWO;
                    in_ready <= 1'b0;
                    skid_idx <= enc_idx;
                    skid_err <= enc_err;
                end else if (pop) begin
                    state     <= EMPTY;
                    out_valid <= 1'b0;
                end
                TWO: if (pop) begin
                    state    <= ONE;
                    in_ready <= 1'b1;
                    out_idx  <= skid_idx;
                    out_err  <= skid_err;
                end
                default: begin
                    state     <= EMPTY;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef ENCODER_ERR_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_cnt <= '0;
        else if (acc && enc_err && err_cnt != ERR_CNT_MAX)
            err_cnt <= err_cnt + 1'b1;
    end
`endif
endmodule

// File: tb/tb_onehot_encoder_stream.sv
// tb_onehot_encoder_stream: directed self-checking bench for onehot_encoder_stream.
module tb_onehot_encoder_stream;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic in_valid = 1'b0;
    logic in_ready;
    logic [3:0] in_code = '0;
    logic out_valid;
    logic out_ready = 1'b0;
    logic [1:0] out_idx;
    logic out_err;
`ifdef ENCODER_ERR_CNT_EN
    logic [7:0] err_cnt;
`endif
    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    onehot_encoder_stream dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_code  (in_code),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_idx  (out_idx),
        .out_err  (out_err)
`ifdef ENCODER_ERR_CNT_EN
        ,
        .err_cnt  (err_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [1:0] idx, input logic err);
        check({tag, ".valid"}, 32'(out_valid), 32'(v));
        check({tag, ".idx"}, 32'(out_idx), 32'(idx));
        check({tag, ".err"}, 32'(out_err), 32'(err));
    endtask

    initial begin
        #2 rst = 1'b1;
        #1;
        check("rst.in_ready", 32'(in_ready), 32'd1);
        check_out("rst", 1'b0, 2'd0, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        check("post_rst.in_ready", 32'(in_ready), 32'd1);
        check_out("post_rst", 1'b0, 2'd0, 1'b0);
`ifdef ENCODER_ERR_CNT_EN
        check("post_rst.err_cnt", 32'(err_cnt), 32'd0);
`endif
        // single word
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_code = 4'b0100;
        cyc();
        in_valid = 1'b0;
        check_out("single", 1'b1, 2'd2, 1'b0);
        cyc();
        check("single.drain", 32'(out_valid), 32'd0);
        // back-to-back stream of every legal code
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_code = 4'b0001 << i;
            cyc();
            check_out($sformatf("stream%0d", i), 1'b1, 2'(i), 1'b0);
            check($sformatf("stream%0d.in_ready", i), 32'(in_ready), 32'd1);
        end
        // error codes
        in_code = 4'b0000;
        cyc();
        check_out("zero_hot", 1'b1, 2'd0, 1'b1);
        in_code = 4'b1010;
        cyc();
        check_out("multi_hot", 1'b1, 2'd3, 1'b1);
        in_valid = 1'b0;
        cyc();
        check("err.drain", 32'(out_valid), 32'd0);
`ifdef ENCODER_ERR_CNT_EN
        check("err_cnt.two", 32'(err_cnt), 32'd2);
`endif
        // back-pressure fills main and skid, third word must wait
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_code = 4'b0001;
        cyc();
        check("bp1.in_ready", 32'(in_ready), 32'd1);
        check_out("bp1", 1'b1, 2'd0, 1'b0);
        in_code = 4'b0010;
        cyc();
        check("bp2.in_ready", 32'(in_ready), 32'd0);
        check_out("bp2", 1'b1, 2'd0, 1'b0);
        in_code = 4'b0100;
        cyc();
        check("bp3.in_ready", 32'(in_ready), 32'd0);
        check_out("bp3", 1'b1, 2'd0, 1'b0);
        out_ready = 1'b1;
        cyc();
        check("bp_pop1.in_ready", 32'(in_ready), 32'd1);
        check_out("bp_pop1", 1'b1, 2'd1, 1'b0);
        cyc();
        in_valid = 1'b0;
        check_out("bp_pop2", 1'b1, 2'd2, 1'b0);
        cyc();
        check("bp.drain", 32'(out_valid), 32'd0);
`ifdef ENCODER_ERR_CNT_EN
        in_valid = 1'b1;
        in_code = 4'b0000;
        repeat (300) cyc();
        check("err_cnt.sat", 32'(err_cnt), 32'd255);
        repeat (5) cyc();
        check("err_cnt.hold", 32'(err_cnt), 32'd255);
        in_valid = 1'b0;
        cyc();
`endif
        // asynchronous reset while in TWO
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_code = 4'b0001;
        cyc();
        in_code = 4'b0010;
        cyc();
        in_valid = 1'b0;
        check("two.in_ready", 32'(in_ready), 32'd0);
        #2 rst = 1'b1;
        #1;
        check("async_rst.valid", 32'(out_valid), 32'd0);
        check("async_rst.in_ready", 32'(in_ready), 32'd1);
`ifdef ENCODER_ERR_CNT_EN
        check("async_rst.err_cnt", 32'(err_cnt), 32'd0);
`endif
        @(posedge clk);
        #1 rst = 1'b0;
        check("rst_rel.valid", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_code = 4'b1000;
        cyc();
        in_valid = 1'b0;
        check_out("after_rst", 1'b1, 2'd3, 1'b0);
        cyc();
        check("after_rst.drain", 32'(out_valid), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
